mbt_core: RTL and testbench
===========================

Name: mbt_core

Overview:
- Mandelbrot iteration engine directly downstream of the pixel-scan controller.
- Accepts a pixel coordinate (x, y) with a one-cycle-wide start.
- Computes escape-iteration counts for 4 horizontally adjacent pixels (x..x+3) in parallel, using Q4.12 signed fixed point.
- Raises mbt_response when all 4 lanes finish and holds it until reset. The controller's rst_MBT feeds this block's rst.

Parameters:
- CR_MIN, -10240, real-axis origin in Q4.12 (-2.5).
- CI_MIN, -5400, imaginary-axis origin in Q4.12 (about -1.318).
- STEP, 18, per-pixel step in Q4.12 (about 0.0044).
- MAX_ITER, 64, iteration cap (1..255).
- LANES, 4, pixels per request (fixed at 4; X stride of the scan).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset (driven by controller rst_MBT).
- start  in  1  request strobe, sampled in IDLE only.
- i_x  in  16  base pixel column (unsigned).
- i_y  in  16  pixel row (unsigned).
- mbt_response  out  1  all lanes finished; held high until rst.
- o_x  out  16  latched base column of the result.
- o_y  out  16  latched row of the result.
- o_iter  out  32  lane k count at bits [8k+7:8k]; lane 0 = pixel i_x.
- DBG_core_state  out  2  current FSM state.

Behaviour:
- Reset: state IDLE. mbt_response=0, o_x=0, o_y=0, o_iter=0. All lane registers (zr, zi, cr, ci, count, stopped) cleared. Reset has priority over every other event, including mid-ITER and DONE.
- States: IDLE=00, INIT=01, ITER=10, DONE=11.
- IDLE:
  - If start=1 at an edge: latch o_x=i_x and o_y=i_y, go to INIT.
  - start in any other state is ignored.
- INIT (1 cycle):
  - cr[k] = CR_MIN + (o_x+k)*STEP.
  - ci = CI_MIN + o_y*STEP.
  - Products use 32-bit signed intermediates; results are truncated to 16 bits.
  - zr=zi=0, count=0, stopped=0. Go to ITER.
- ITER, each edge, for every lane with stopped=0:
  - mag = zr^2 + zi^2, computed as 32-bit products >>>12.
  - If mag > 16384 (4.0): set stopped=1; count is unchanged.
  - Otherwise:
    - zr <= ((zr^2 - zi^2) >>> 12) + cr
    - zi <= ((2*zr*zi) >>> 12) + ci
    - count <= count + 1
    - If count+1 == MAX_ITER, set stopped=1.
  - Lanes with stopped=1 hold all their registers.
- Exit from ITER: at the edge where the last lane stops, go to DONE. o_iter is loaded with the final counts at that same edge.
- DONE:
  - mbt_response=1; o_iter, o_x and o_y are stable.
  - Stays in DONE until rst; there is no self-clear.
- Latency:
  - Let K be the ITER cycles needed for the slowest lane to stop.
  - mbt_response rises K+1 edges after the edge that sampled start.
  - K ≤ MAX_ITER+1.
- Arithmetic: no saturation. Only non-escaped values are iterated (|z| ≤ 2 before each update), so magnitudes stay within the Q4.12 range.
- Simultaneous rst=1 and DONE (controller ORs mbt_response into rst_MBT): the next edge returns to IDLE and clears outputs. Results must be consumed in the cycle mbt_response is high.

Optional Feature:
- Macro MBT_PIPE_MUL_EN.
- Defined:
  - ITER splits into two cycles per iteration. Sub-cycle A registers zr^2, zi^2 and zr*zi; sub-cycle B does the compare and update.
  - DBG_core_state stays 10 during both sub-cycles.
  - Latency becomes 2K+1 edges.
- Undefined: single-cycle iteration as described above.
- Counts and outputs are identical in both modes.

Test Plan:
- Reset mid-ITER:
  - Stimulus: start with x=568, y=300, then rst=1 after 10 cycles.
  - Response: next edge IDLE, mbt_response=0, o_iter=0.
  - Then start with x=0, y=0 again: response asserts normally.
- Far-outside request:
  - Stimulus: start with x=0, y=0 (all lanes |c|^2 > 4).
  - Response: o_iter=0x01010101, mbt_response high 3 edges after start sample (K=2).
- In-set request:
  - Stimulus: start with x=568, y=300 (c ≈ 0), MAX_ITER=64.
  - Response: o_iter=0x40404040, mbt_response after 65 edges.
- Ignored start and held response:
  - Stimulus: pulse start during ITER and again in DONE.
  - Response: no relatch, o_x and o_y unchanged, mbt_response held until rst.
- Controller handshake:
  - Stimulus: loop rst=mbt_response, issue back-to-back requests for x=0,4,8.
  - Response: each result is captured exactly once, and o_x matches the request.
- Mode equivalence:
  - Stimulus: build with MBT_PIPE_MUL_EN and run the same stimuli as above.
  - Response: identical o_iter; latency is 2K+1 edges (5 for the x=0, y=0 case).

Source files
------------

// File: rtl/mbt_core.sv
// Mandelbrot escape-count engine: four horizontally adjacent pixels per request, Q4.12 fixed point.
// Optional macro MBT_PIPE_MUL_EN splits each iteration into a multiply cycle and an update cycle.
module mbt_core #(
  parameter int CR_MIN   = -10240,
  parameter int CI_MIN   = -5400,
  parameter int STEP     = 18,
  parameter int MAX_ITER = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  output logic        mbt_response,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic [31:0] o_iter,
  output logic [1:0]  DBG_core_state
);
  localparam int LANES = 4;

  typedef enum logic [1:0] {IDLE = 2'b00, INIT = 2'b01, ITER = 2'b10, DONE = 2'b11} state_t;

  // Handshake: start is a one-cycle strobe honoured only in IDLE; mbt_response then stays
  // high with o_x/o_y/o_iter stable until rst, so the consumer must take results while it is high.
  state_t             state_q;
  logic               resp_q;
  logic [15:0]        x_q, y_q;
  logic [31:0]        iter_q;
  logic signed [15:0] zr_q [LANES];
  logic signed [15:0] zi_q [LANES];
  logic signed [15:0] cr_q [LANES];
  logic signed [15:0] ci_q;
  logic [7:0]         cnt_q [LANES];
  logic [LANES-1:0]   stop_q;

  logic signed [15:0] cr_init [LANES];
  logic signed [15:0] ci_init;
  logic signed [31:0] p_rr [LANES];
  logic signed [31:0] p_ii [LANES];
  logic signed [31:0] p_ri [LANES];
  logic signed [31:0] u_rr [LANES];
  logic signed [31:0] u_ii [LANES];
  logic signed [31:0] u_ri [LANES];
  logic signed [31:0] mag  [LANES];
  logic signed [15:0] zr_nx [LANES];
  logic signed [15:0] zi_nx [LANES];
  logic [7:0]         cnt_nx [LANES];
  logic [LANES-1:0]   esc;
  logic [LANES-1:0]   stop_nx;
  logic [31:0]        iter_nx;
  logic               upd_en;

  always_comb begin
    ci_init = 16'(CI_MIN + int'({16'd0, y_q}) * STEP);
    iter_nx = '0;
    esc     = '0;
    stop_nx = stop_q;
    for (int k = 0; k < LANES; k++) begin
      cr_init[k] = 16'(CR_MIN + (int'({16'd0, x_q}) + k) * STEP);
      p_rr[k]    = 32'(zr_q[k]) * 32'(zr_q[k]);
      p_ii[k]    = 32'(zi_q[k]) * 32'(zi_q[k]);
      p_ri[k]    = 32'(zr_q[k]) * 32'(zi_q[k]);
      mag[k]     = (u_rr[k] + u_ii[k]) >>> 12;
      esc[k]     = mag[k] > 32'sd16384;
      zr_nx[k]   = 16'(((u_rr[k] - u_ii[k]) >>> 12) + 32'(cr_q[k]));
      zi_nx[k]   = 16'(((u_ri[k] <<< 1) >>> 12) + 32'(ci_q));
      cnt_nx[k]  = cnt_q[k];
      if (!stop_q[k]) begin
        if (esc[k]) begin
          stop_nx[k] = 1'b1;
        end else begin
          cnt_nx[k] = cnt_q[k] + 8'd1;
          if (cnt_q[k] + 8'd1 == 8'(MAX_ITER)) stop_nx[k] = 1'b1;
        end
      end
      iter_nx[8*k +: 8] = cnt_nx[k];
    end
  end

`ifdef MBT_PIPE_MUL_EN
  // Sub-cycle A (ph_q=0) captures the products; sub-cycle B (ph_q=1) compares and updates.
  logic               ph_q;
  logic signed [31:0] prr_q [LANES];
  logic signed [31:0] pii_q [LANES];
  logic signed [31:0] pri_q [LANES];

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        prr_q[k] <= '0;
        pii_q[k] <= '0;
        pri_q[k] <= '0;
      end
    end else if (state_q == ITER) begin
      ph_q <= ~ph_q;
      if (!ph_q) begin
        prr_q <= p_rr;
        pii_q <= p_ii;
        pri_q <= p_ri;
      end
    end else begin
      ph_q <= 1'b0;
    end
  end

  assign upd_en = ph_q;
  assign u_rr   = prr_q;
  assign u_ii   = pii_q;
  assign u_ri   = pri_q;
`else
  assign upd_en = 1'b1;
  assign u_rr   = p_rr;
  assign u_ii   = p_ii;
  assign u_ri   = p_ri;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      resp_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      iter_q  <= '0;
      ci_q    <= '0;
      stop_q  <= '0;
      for (int k = 0; k < LANES; k++) begin
        zr_q[k]  <= '0;
        zi_q[k]  <= '0;
        cr_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= i_x;
            y_q     <= i_y;
            state_q <= INIT;
          end
        end
        INIT: begin
          ci_q   <= ci_init;
          stop_q <= '0;
          for (int k = 0; k < LANES; k++) begin
            cr_q[k]  <= cr_init[k];
            zr_q[k]  <= '0;
            zi_q[k]  <= '0;
            cnt_q[k] <= '0;
          end
          state_q <= ITER;
        end
        ITER: begin
          if (upd_en) begin
            // Escaping lanes keep z and count; only lanes still inside |z|<=2 advance.
            for (int k = 0; k < LANES; k++) begin
              if (!stop_q[k] && !esc[k]) begin
                zr_q[k] <= zr_nx[k];
                zi_q[k] <= zi_nx[k];
              end
            end
            cnt_q  <= cnt_nx;
            stop_q <= stop_nx;
            if (&stop_nx) begin
              iter_q  <= iter_nx;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mbt_response   = resp_q;
  assign o_x            = x_q;
  assign o_y            = y_q;
  assign o_iter         = iter_q;
  assign DBG_core_state = state_q;
endmodule

// File: tb/tb_mbt_core.sv
// Self-checking bench for mbt_core: fixed vector table, random pixels against a reference model,
// and hand-written reset / ignored-start / controller-handshake sequences.
module tb_mbt_core;
  localparam int CR_MIN   = -10240;
  localparam int CI_MIN   = -5400;
  localparam int STEP     = 18;
  localparam int MAX_ITER = 64;
  localparam int BOUND    = 400;
`ifdef MBT_PIPE_MUL_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic        clk;
  logic        rst_tb;
  logic        hs_mode;
  logic        start;
  logic [15:0] i_x, i_y;
  logic        mbt_response;
  logic [15:0] o_x, o_y;
  logic [31:0] o_iter;
  logic [1:0]  DBG_core_state;
  wire         rst = hs_mode ? mbt_response : rst_tb;

  int n_vec = 0;
  int n_bad = 0;
  logic [47:0] exp_q[$];

  mbt_core dut (
    .clk(clk), .rst(rst), .start(start), .i_x(i_x), .i_y(i_y),
    .mbt_response(mbt_response), .o_x(o_x), .o_y(o_y), .o_iter(o_iter),
    .DBG_core_state(DBG_core_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] iter;
    int          k;
  } vec_t;

  function automatic int lat_of(input int k);
    return (PIPE != 0) ? 2 * k + 1 : k + 1;
  endfunction

  function automatic longint s16(input longint v);
    logic signed [15:0] t;
    t = v[15:0];
    return longint'(t);
  endfunction

  // Reference: iterate z <- z^2 + c for each pixel; K = cycles the slowest lane spends.
  function automatic void model(input int x, input int y, output logic [31:0] iter, output int kmax);
    longint cr, ci, zr, zi, rr, ii, ri, nzr;
    int cnt, steps;
    bit fin;
    kmax = 0;
    iter = '0;
    for (int k = 0; k < 4; k++) begin
      cr = s16(CR_MIN + longint'(x + k) * STEP);
      ci = s16(CI_MIN + longint'(y) * STEP);
      zr = 0; zi = 0; cnt = 0; steps = 0; fin = 0;
      while (!fin) begin
        rr = zr * zr; ii = zi * zi; ri = zr * zi;
        steps++;
        if (((rr + ii) >>> 12) > 16384) begin
          fin = 1;
        end else begin
          nzr = s16(((rr - ii) >>> 12) + cr);
          zi  = s16(((2 * ri) >>> 12) + ci);
          zr  = nzr;
          cnt++;
          if (cnt == MAX_ITER) fin = 1;
        end
      end
      iter[8*k +: 8] = 8'(cnt);
      if (steps > kmax) kmax = steps;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset;
    @(negedge clk);
    rst_tb = 1'b1;
    @(posedge clk);
    #1 rst_tb = 1'b0;
  endtask

  task automatic do_req(input logic [15:0] x, input logic [15:0] y,
                        output logic [31:0] it, output int lat, output bit ok);
    @(negedge clk);
    i_x = x; i_y = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("init_state", 32'(DBG_core_state), 32'd1);
    lat = 0; ok = 0;
    for (int e = 1; e <= BOUND; e++) begin
      @(posedge clk);
      #1;
      if (mbt_response) begin
        lat = e; ok = 1;
        break;
      end
    end
    it = o_iter;
  endtask

  vec_t        tbl[4];
  logic [31:0] got_it, m_it;
  int          lat, mk;
  bit          ok;
  logic [15:0] hs_x[3];
  logic [47:0] ent;
  int          caps;

  initial begin
    rst_tb = 1'b1; hs_mode = 1'b0; start = 1'b0; i_x = '0; i_y = '0;
    tbl[0] = '{x: 16'd0,    y: 16'd0,   iter: 32'h01010101, k: 2};
    tbl[1] = '{x: 16'd568,  y: 16'd300, iter: 32'h40404040, k: 64};
    tbl[2] = '{x: 16'd0,    y: 16'd600, iter: 32'h01010101, k: 2};
    tbl[3] = '{x: 16'd1000, y: 16'd0,   iter: 32'h01010101, k: 2};

    repeat (2) @(posedge clk);
    #1 rst_tb = 1'b0;
    check("rst_state", 32'(DBG_core_state), 32'd0);
    check("rst_resp", 32'(mbt_response), 32'd0);
    check("rst_ox", 32'(o_x), 32'd0);
    check("rst_oy", 32'(o_y), 32'd0);
    check("rst_iter", o_iter, 32'd0);

    // table vectors
    for (int i = 0; i < 4; i++) begin
      do_reset;
      do_req(tbl[i].x, tbl[i].y, got_it, lat, ok);
      check("tbl_timeout", 32'(ok), 32'd1);
      check("tbl_iter", got_it, tbl[i].iter);
      check("tbl_latency", 32'(lat), 32'(lat_of(tbl[i].k)));
      check("tbl_ox", 32'(o_x), 32'(tbl[i].x));
      check("tbl_oy", 32'(o_y), 32'(tbl[i].y));
      check("tbl_done_state", 32'(DBG_core_state), 32'd3);
    end

    // randomized pixels near the set boundary
    for (int i = 0; i < 24; i++) begin
      i_x = 16'($urandom_range(380, 700));
      i_y = 16'($urandom_range(120, 480));
      model(int'(i_x), int'(i_y), m_it, mk);
      do_reset;
      do_req(i_x, i_y, got_it, lat, ok);
      check("rnd_timeout", 32'(ok), 32'd1);
      check("rnd_iter", got_it, m_it);
      check("rnd_latency", 32'(lat), 32'(lat_of(mk)));
    end

    // reset in the middle of ITER, then a normal request
    do_reset;
    @(negedge clk);
    i_x = 16'd568; i_y = 16'd300; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("mid_iter_state", 32'(DBG_core_state), 32'd2);
    @(negedge clk) rst_tb = 1'b1;
    @(posedge clk);
    #1 rst_tb = 1'b0;
    check("midrst_state", 32'(DBG_core_state), 32'd0);
    check("midrst_resp", 32'(mbt_response), 32'd0);
    check("midrst_iter", o_iter, 32'd0);
    check("midrst_ox", 32'(o_x), 32'd0);
    do_req(16'd0, 16'd0, got_it, lat, ok);
    check("after_rst_timeout", 32'(ok), 32'd1);
    check("after_rst_iter", got_it, 32'h01010101);
    check("after_rst_latency", 32'(lat), 32'(lat_of(2)));

    // start pulses during ITER and DONE are ignored; response holds
    do_reset;
    @(negedge clk);
    i_x = 16'd568; i_y = 16'd300; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ok = 0; lat = 0;
    for (int e = 1; e <= BOUND; e++) begin
      @(posedge clk);
      #1;
      if (mbt_response) begin
        ok = 1; lat = e;
        break;
      end
      if (e == 5) begin
        i_x = 16'd100; i_y = 16'd7; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("ign_timeout", 32'(ok), 32'd1);
    check("ign_latency", 32'(lat), 32'(lat_of(64)));
    check("ign_ox", 32'(o_x), 32'd568);
    check("ign_oy", 32'(o_y), 32'd300);
    @(negedge clk);
    i_x = 16'd4; i_y = 16'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_resp", 32'(mbt_response), 32'd1);
    check("hold_state", 32'(DBG_core_state), 32'd3);
    check("hold_ox", 32'(o_x), 32'd568);
    check("hold_oy", 32'(o_y), 32'd300);
    check("hold_iter", o_iter, 32'h40404040);

    // controller handshake: rst follows mbt_response, back-to-back requests
    do_reset;
    hs_x[0] = 16'd0; hs_x[1] = 16'd4; hs_x[2] = 16'd8;
    for (int r = 0; r < 3; r++) begin
      model(int'(hs_x[r]), 300, m_it, mk);
      exp_q.push_back({hs_x[r], m_it});
    end
    hs_mode = 1'b1;
    caps = 0;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      i_x = hs_x[r]; i_y = 16'd300; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      ok = 0;
      for (int e = 1; e <= BOUND; e++) begin
        @(posedge clk);
        #1;
        if (mbt_response) begin
          ok = 1;
          break;
        end
      end
      check("hs_timeout", 32'(ok), 32'd1);
      if (ok) begin
        caps++;
        ent = exp_q.pop_front();
        check("hs_ox", 32'(o_x), 32'(ent[47:32]));
        check("hs_iter", o_iter, ent[31:0]);
      end
      @(posedge clk);
      #1;
      check("hs_single_resp", 32'(mbt_response), 32'd0);
      check("hs_idle", 32'(DBG_core_state), 32'd0);
    end
    check("hs_captures", 32'(caps), 32'd3);
    hs_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
